// File: rtl/tboom_freelist_nway.sv
// N-wide physical register free list for rename, with head checkpoints for branch recovery.
// Defining TBOOM_FL_WATERMARK_EN adds parameter LOW_WATERMARK and a registered almost_empty output.
module tboom_freelist_nway #(
    parameter int PHYS_ADDR_WIDTH  = 6,
    parameter int NUM_ARCH_REGS    = 32,
    parameter int NUM_PHYS_REGS    = 64,
    parameter int ALLOC_WIDTH      = 2,
    parameter int FREE_WIDTH       = 2,
    parameter int CHECKPOINT_DEPTH = 8
`ifdef TBOOM_FL_WATERMARK_EN
    ,
    parameter int LOW_WATERMARK    = ALLOC_WIDTH
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [ALLOC_WIDTH-1:0]                    alloc_req,
    output logic [ALLOC_WIDTH*PHYS_ADDR_WIDTH-1:0]    alloc_pdst,
    output logic                                      alloc_stall,
    input  logic [FREE_WIDTH-1:0]                     free_valid,
    input  logic [FREE_WIDTH*PHYS_ADDR_WIDTH-1:0]     free_pdst,
    input  logic                                      checkpoint,
    input  logic                                      restore,
    input  logic [$clog2(CHECKPOINT_DEPTH)-1:0]       checkpoint_restore_pos,
    output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] free_count,
    output logic                                      err
`ifdef TBOOM_FL_WATERMARK_EN
    ,
    output logic                                      almost_empty
`endif
);

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PHYS_ADDR_WIDTH-1:0] buffer [DEPTH];
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [PTR_W-1:0]           ckpt_head [CHECKPOINT_DEPTH];
    logic [CHECKPOINT_DEPTH-1:0] ckpt_valid;

    logic [PTR_W-1:0]           alloc_n;
    logic                       alloc_block;
    logic [IDX_W-1:0]           wr_idx [FREE_WIDTH];
    logic [FREE_WIDTH-1:0]      wr_en;
    logic                       free_drop;
    logic [PTR_W-1:0]           tail_next;
    logic [PTR_W-1:0]           head_sel;
    logic [PTR_W-1:0]           head_next;
    logic [PTR_W-1:0]           raw_count;
    logic [PTR_W-1:0]           count_next;
    logic                       saturate;
    logic                       restore_hit;
    logic                       restore_miss;

    always_comb begin
        alloc_n = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_n = alloc_n + PTR_W'(alloc_req[k]);
        end
    end

    // Stall is judged on the registered count only; a restore cycle never allocates.
    assign alloc_block = restore || (alloc_n > free_count);
    assign alloc_stall = rst_n && alloc_block;

    always_comb begin
        logic [PTR_W-1:0] offset;
        offset     = '0;
        alloc_pdst = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (alloc_req[k]) begin
                if (rst_n && !alloc_block) begin
                    alloc_pdst[k*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] = buffer[IDX_W'(head + offset)];
                end
                offset = offset + PTR_W'(1);
            end
        end
    end

    // Free capacity is measured against the pre-allocation count so a write never lands on a live entry.
    always_comb begin
        logic [PTR_W-1:0] accepted;
        accepted  = '0;
        free_drop = 1'b0;
        wr_en     = '0;
        for (int k = 0; k < FREE_WIDTH; k++) begin
            wr_idx[k] = IDX_W'(tail + accepted);
            if (free_valid[k] && (free_pdst[k*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] != '0)) begin
                if ((free_count + accepted) < PTR_W'(DEPTH)) begin
                    wr_en[k] = 1'b1;
                    accepted = accepted + PTR_W'(1);
                end else begin
                    free_drop = 1'b1;
                end
            end
        end
        tail_next = tail + accepted;
    end

    assign restore_hit  = restore && ckpt_valid[checkpoint_restore_pos];
    assign restore_miss = restore && !ckpt_valid[checkpoint_restore_pos];

    // An over-full restore pulls head up so that tail - head stays equal to the saturated count.
    always_comb begin
        if (restore_hit) begin
            head_sel = ckpt_head[checkpoint_restore_pos];
        end else if (!alloc_block) begin
            head_sel = head + alloc_n;
        end else begin
            head_sel = head;
        end
        raw_count  = tail_next - head_sel;
        saturate   = raw_count > PTR_W'(DEPTH);
        head_next  = saturate ? (tail_next - PTR_W'(DEPTH)) : head_sel;
        count_next = saturate ? PTR_W'(DEPTH) : raw_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= PHYS_ADDR_WIDTH'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < CHECKPOINT_DEPTH; c++) begin
                ckpt_head[c] <= '0;
            end
            head       <= '0;
            tail       <= PTR_W'(DEPTH);
            free_count <= PTR_W'(DEPTH);
            ckpt_valid <= '0;
            err        <= 1'b0;
        end else begin
            for (int k = 0; k < FREE_WIDTH; k++) begin
                if (wr_en[k]) begin
                    buffer[wr_idx[k]] <= free_pdst[k*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH];
                end
            end
            head       <= head_next;
            tail       <= tail_next;
            free_count <= count_next;
            if (restore_hit) begin
                ckpt_valid[checkpoint_restore_pos] <= 1'b0;
            end else if (checkpoint && !restore) begin
                ckpt_head[checkpoint_restore_pos]  <= head;
                ckpt_valid[checkpoint_restore_pos] <= 1'b1;
            end
            if (free_drop || restore_miss || saturate) begin
                err <= 1'b1;
            end
        end
    end

`ifdef TBOOM_FL_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_empty <= 1'b0;
        end else begin
            almost_empty <= count_next < PTR_W'(LOW_WATERMARK);
        end
    end
`endif

endmodule

// File: tb/tb_tboom_freelist_nway.sv
// Self-checking bench for tboom_freelist_nway: directed scenarios plus randomized traffic
// compared every cycle against an array/pointer reference model of the free list rules.
`timescale 1ns/1ps
module tb_tboom_freelist_nway;

    localparam int W     = 6;
    localparam int DEPTH = 32;
    localparam int AW    = 2;
    localparam int FW    = 2;
    localparam int CD    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] alloc_req;
    logic [AW*W-1:0] alloc_pdst;
    logic          alloc_stall;
    logic [FW-1:0] free_valid;
    logic [FW*W-1:0] free_pdst;
    logic          checkpoint;
    logic          restore;
    logic [2:0]    checkpoint_restore_pos;
    logic [5:0]    free_count;
    logic          err;
`ifdef TBOOM_FL_WATERMARK_EN
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    tboom_freelist_nway #(
        .PHYS_ADDR_WIDTH (W),
        .NUM_ARCH_REGS   (32),
        .NUM_PHYS_REGS   (64),
        .ALLOC_WIDTH     (AW),
        .FREE_WIDTH      (FW),
        .CHECKPOINT_DEPTH(CD)
`ifdef TBOOM_FL_WATERMARK_EN
        ,
        .LOW_WATERMARK   (2)
`endif
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alloc_req             (alloc_req),
        .alloc_pdst            (alloc_pdst),
        .alloc_stall           (alloc_stall),
        .free_valid            (free_valid),
        .free_pdst             (free_pdst),
        .checkpoint            (checkpoint),
        .restore               (restore),
        .checkpoint_restore_pos(checkpoint_restore_pos),
        .free_count            (free_count),
        .err                   (err)
`ifdef TBOOM_FL_WATERMARK_EN
        ,
        .almost_empty          (almost_empty)
`endif
    );

    // Reference model: the list as a ring of values with free-running head/tail modulo 64.
    int m_mem [DEPTH];
    int m_head;
    int m_tail;
    int m_count;
    int m_ch [CD];
    bit m_cv [CD];
    bit m_err;
    bit m_ae;

    int checks;
    int errors;
    int obs_lane [AW];
    int obs_count;
    int obs_err;
    bit obs_stall;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32 + i;
        for (int c = 0; c < CD; c++) begin
            m_ch[c] = 0;
            m_cv[c] = 1'b0;
        end
        m_head  = 0;
        m_tail  = DEPTH;
        m_count = DEPTH;
        m_err   = 1'b0;
        m_ae    = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n      = 1'b0;
        alloc_req  = '1;
        restore    = 1'b1;
        checkpoint = 1'b0;
        free_valid = '0;
        free_pdst  = '0;
        checkpoint_restore_pos = '0;
        #1;
        checkOutput("rst_stall", 32'(alloc_stall), 32'd0);
        checkOutput("rst_pdst", 32'(alloc_pdst), 32'd0);
        checkOutput("rst_count", 32'(free_count), 32'd32);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        restore   = 1'b0;
        alloc_req = '0;
        modelReset();
    endtask

    // One cycle: drive at the falling edge, check outputs, then advance the model past the rising edge.
    task automatic applyStimulus(input logic [AW-1:0] req, input logic [FW-1:0] fv,
                                 input logic [FW*W-1:0] fp, input logic ck, input logic rs,
                                 input logic [2:0] pos);
        int n;
        int idx;
        int acc;
        int new_head;
        int new_tail;
        int cnt;
        int fpk;
        bit stall;
        int exp_lane [AW];
        @(negedge clk);
        alloc_req  = req;
        free_valid = fv;
        free_pdst  = fp;
        checkpoint = ck;
        restore    = rs;
        checkpoint_restore_pos = pos;
        #1;
        checkOutput("free_count", 32'(free_count), 32'(m_count));
        checkOutput("err", 32'(err), 32'(m_err));
`ifdef TBOOM_FL_WATERMARK_EN
        checkOutput("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
        n = $countones(req);
        stall = rs || (n > m_count);
        idx = 0;
        for (int k = 0; k < AW; k++) begin
            exp_lane[k] = 0;
            if (req[k]) begin
                if (!stall) exp_lane[k] = m_mem[(m_head + idx) % DEPTH];
                idx++;
            end
        end
        checkOutput("alloc_stall", 32'(alloc_stall), 32'(stall));
        for (int k = 0; k < AW; k++) begin
            obs_lane[k] = int'(alloc_pdst[k*W +: W]);
            checkOutput($sformatf("pdst_lane%0d", k), 32'(obs_lane[k]), 32'(exp_lane[k]));
        end
        obs_stall = alloc_stall;
        obs_count = int'(free_count);
        obs_err   = int'(err);

        acc = 0;
        for (int k = 0; k < FW; k++) begin
            fpk = int'(fp[k*W +: W]);
            if (fv[k] && fpk != 0) begin
                if (m_count + acc < DEPTH) begin
                    m_mem[(m_tail + acc) % DEPTH] = fpk;
                    acc++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        new_tail = (m_tail + acc) & 63;
        if (rs && m_cv[pos]) begin
            new_head = m_ch[pos];
            m_cv[pos] = 1'b0;
        end else if (rs) begin
            new_head = m_head;
            m_err = 1'b1;
        end else if (!stall) begin
            new_head = (m_head + n) & 63;
        end else begin
            new_head = m_head;
        end
        if (ck && !rs) begin
            m_ch[pos] = m_head;
            m_cv[pos] = 1'b1;
        end
        cnt = (new_tail - new_head) & 63;
        if (cnt > DEPTH) begin
            m_err = 1'b1;
            cnt = DEPTH;
            new_head = (new_tail - DEPTH) & 63;
        end
        m_head  = new_head;
        m_tail  = new_tail;
        m_count = cnt;
        m_ae    = cnt < 2;
    endtask

    function automatic logic [FW*W-1:0] randFree();
        logic [FW*W-1:0] v;
        for (int k = 0; k < FW; k++) begin
            v[k*W +: W] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        alloc_req = '0;
        free_valid = '0;
        free_pdst = '0;
        checkpoint = 1'b0;
        restore = 1'b0;
        checkpoint_restore_pos = '0;
        modelReset();

        // Two full-width allocations right after reset.
        doReset();
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("A_first_lane0", 32'(obs_lane[0]), 32'd32);
        checkOutput("A_first_lane1", 32'(obs_lane[1]), 32'd33);
        checkOutput("A_first_count", 32'(obs_count), 32'd32);
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("A_second_lane0", 32'(obs_lane[0]), 32'd34);
        checkOutput("A_second_lane1", 32'(obs_lane[1]), 32'd35);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("A_count28", 32'(obs_count), 32'd28);

        // Lane compaction.
        doReset();
        applyStimulus(2'b10, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("B_lane1_only", 32'(obs_lane[1]), 32'd32);
        checkOutput("B_lane0_idle", 32'(obs_lane[0]), 32'd0);
        applyStimulus(2'b01, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("B_lane0_next", 32'(obs_lane[0]), 32'd33);

        // Drain to empty, stall with a same-cycle free, then allocate the freed register.
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b11, 2'b01, {6'd0, 6'd5}, 1'b0, 1'b0, 3'd0);
        checkOutput("C_empty_count", 32'(obs_count), 32'd0);
        checkOutput("C_empty_stall", 32'(obs_stall), 32'd1);
        checkOutput("C_empty_pdst0", 32'(obs_lane[0]), 32'd0);
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("C_one_count", 32'(obs_count), 32'd1);
        checkOutput("C_one_stall2", 32'(obs_stall), 32'd1);
        applyStimulus(2'b01, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("C_freed_reg", 32'(obs_lane[0]), 32'd5);

        // Checkpoint and restore.
        doReset();
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b11, 2'b00, '0, 1'b1, 1'b0, 3'd0);
        checkOutput("D_ckpt_lane0", 32'(obs_lane[0]), 32'd34);
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("D_post_lane1", 32'(obs_lane[1]), 32'd37);
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b1, 3'd0);
        checkOutput("D_restore_stall", 32'(obs_stall), 32'd1);
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("D_replay_lane0", 32'(obs_lane[0]), 32'd34);
        checkOutput("D_replay_lane1", 32'(obs_lane[1]), 32'd35);
        checkOutput("D_replay_count", 32'(obs_count), 32'd30);

        // Zero free ignored, invalid restore flags sticky err.
        doReset();
        applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b00, 2'b01, '0, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b1, 3'd3);
        checkOutput("E_zero_free_count", 32'(obs_count), 32'd30);
        checkOutput("E_zero_free_err", 32'(obs_err), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("E_err_sticky", 32'(obs_err), 32'd1);

        // Free into a full list is dropped and flags err.
        doReset();
        applyStimulus(2'b00, 2'b01, {6'd0, 6'd7}, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("F_full_count", 32'(obs_count), 32'd32);
        checkOutput("F_full_err", 32'(obs_err), 32'd1);

`ifdef TBOOM_FL_WATERMARK_EN
        // Watermark: count 2 is not almost-empty, count 1 is, seen on the same edge.
        doReset();
        for (int i = 0; i < 15; i++) applyStimulus(2'b11, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        applyStimulus(2'b01, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("G_count2", 32'(obs_count), 32'd2);
        checkOutput("G_ae_at2", 32'(almost_empty), 32'd0);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0, 3'd0);
        checkOutput("G_count1", 32'(obs_count), 32'd1);
        checkOutput("G_ae_at1", 32'(almost_empty), 32'd1);
`endif

        // Randomized traffic with periodic mid-run resets.
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [FW-1:0] fv;
            for (int k = 0; k < FW; k++) fv[k] = ($urandom_range(0, 2) == 0);
            applyStimulus(2'($urandom_range(0, 3)), fv, randFree(),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                          3'($urandom_range(0, CD - 1)));
            if (cyc % 500 == 499) doReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tboom_freelist_nway.md
Name: tboom_freelist_nway

Overview:
- Parametrised N-wide physical-register free list for the TinyBOOM rename stage; successor to the fixed 2-wide free list inside the rename unit.
- Circular buffer of free physical register indices: ALLOC_WIDTH allocations per cycle from the head, FREE_WIDTH commit-time frees per cycle at the tail.
- CHECKPOINT_DEPTH head-pointer snapshots for branch-misprediction recovery.
- The rename map table instantiates this block and consumes alloc_pdst as new pdst values.

Parameters:
- PHYS_ADDR_WIDTH, 6, physical register index width.
- NUM_ARCH_REGS, 32, architectural registers; phys 0..NUM_ARCH_REGS-1 are mapped at reset.
- NUM_PHYS_REGS, 64, total physical registers; DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS, must be a power of two.
- ALLOC_WIDTH, 2, allocation lanes per cycle (1..4).
- FREE_WIDTH, 2, free lanes per cycle (1..4).
- CHECKPOINT_DEPTH, 8, number of head snapshots.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- alloc_req  in  ALLOC_WIDTH  per-lane allocation request.
- alloc_pdst  out  ALLOC_WIDTH*PHYS_ADDR_WIDTH  per-lane allocated physical reg; lane k at bits [k*W +: W].
- alloc_stall  out  1  insufficient free entries; nothing allocated this cycle.
- free_valid  in  FREE_WIDTH  per-lane free request (commit of stale pdst).
- free_pdst  in  FREE_WIDTH*PHYS_ADDR_WIDTH  physical reg to return.
- checkpoint  in  1  snapshot head into slot checkpoint_restore_pos.
- restore  in  1  roll head back to slot checkpoint_restore_pos.
- checkpoint_restore_pos  in  $clog2(CHECKPOINT_DEPTH)  slot select.
- free_count  out  $clog2(DEPTH)+1  registered number of free entries.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer entry i = NUM_ARCH_REGS+i.
  - head=0, tail=DEPTH (pointers carry one extra wrap bit), free_count=DEPTH.
  - All checkpoint valid bits cleared, err=0.
  - alloc_stall=0 and alloc_pdst all 0 while in reset.
- Assertion of rst_n mid-operation discards all state, including checkpoints.
- Allocation (combinational outputs, state update at next posedge):
  - n = popcount(alloc_req).
  - Requested lane k gets buffer[head + popcount(alloc_req[k-1:0])]. Lanes are compacted, so a lane-1-only request gets the head entry.
  - Unrequested lanes output 0.
  - If n > free_count: alloc_stall=1, all alloc_pdst=0, head unchanged (all-or-nothing).
  - Otherwise head += n at the edge.
- Frees in the same cycle do not relieve the stall; it is computed from the registered free_count only.
- Free:
  - Valid lanes are written at tail in ascending lane order, compacted; tail += number accepted.
  - free_pdst==0 is ignored silently; phys 0 is never in the list.
  - A free that would make the count exceed DEPTH is dropped and sets err.
- free_count_next = tail_next - head_next, modulo the 2^(log2 DEPTH+1) pointer width.
- Checkpoint:
  - Slot pos saves head as it was before this cycle's allocation, and sets valid[pos].
  - Allocation in the same cycle proceeds normally.
  - Overwriting a valid slot is legal.
- Restore:
  - If valid[pos]=1: head <= saved head; valid[pos] cleared.
  - Allocation is suppressed on the restore cycle: alloc_stall=1, alloc_pdst=0.
  - Frees on the same cycle are still accepted; tail is not restored.
  - If valid[pos]=0: restore is ignored and err is set.
  - If the resulting count would exceed DEPTH: err is set and the count saturates at DEPTH.
- checkpoint and restore asserted together: restore wins, checkpoint ignored.
- err clears only on reset.

Optional Feature:
- Macro TBOOM_FL_WATERMARK_EN.
- Defined:
  - Adds parameter LOW_WATERMARK (default ALLOC_WIDTH) and output almost_empty (1 bit).
  - almost_empty is registered: 1 when free_count_next < LOW_WATERMARK; resets to 0.
  - Lets the decoder throttle a cycle early.
- Undefined: no extra parameter or port; all other behaviour identical.

Test Plan:
- Reset release -> free_count=32, err=0. alloc_req=2'b11 -> alloc_pdst={33,32}, no stall; next cycle same request -> {35,34}, free_count=28.
- alloc_req=2'b10 after reset -> lane1=32, lane0=0; following 2'b01 -> lane0=33.
- 16 cycles of 2'b11 -> free_count=0; 17th cycle -> alloc_stall=1, pdst=0, head unchanged. Same cycle free_valid=2'b01 with pdst 5 -> next cycle free_count=1; 2'b11 still stalls, 2'b01 returns 5.
- 2'b11 -> 32,33. checkpoint pos 0 with 2'b11 -> 34,35. 2'b11 -> 36,37. restore pos 0 -> stall that cycle. Next 2'b11 -> 34,35, free_count=30.
- free_pdst=0 with free_valid=1 -> count unchanged, err=0. restore to never-written slot 3 -> head unchanged, err=1 (sticky until reset).
- With TBOOM_FL_WATERMARK_EN and LOW_WATERMARK=2: drain to count 2 -> almost_empty=0; one more single alloc -> almost_empty=1 on the same edge the count becomes 1.
